// File: rtl/wave_capture.sv
`default_nettype none
// ============================================================================
//  Module      : wave_capture
//  Description : Trigger-and-capture record buffer for the oscilloscope
//                datapath. Decimated samples stream into a circular buffer.
//                A hysteresis-qualified edge trigger (normal, auto or single
//                mode) freezes a DEPTH-sample record holding PRE_TRIG samples
//                before the trigger. The frozen record is read back by
//                trigger-relative index.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    ad_clk        in   clock for the whole block
//    rst_n         in   asynchronous active-low reset
//    din           in   decimated sample (DATA_W)
//    din_valid     in   sample strobe
//    run           in   acquisition enable (level)
//    arm           in   single-mode arm pulse (used in IDLE only)
//    trig_mode     in   0 normal, 1 auto, 2 single, 3 normal
//    trig_edge     in   0 rising, 1 falling, 2/3 either
//    trig_level    in   trigger threshold (DATA_W)
//    rd_done       in   reader releases the frozen record
//    rd_en         in   read strobe
//    rd_idx        in   trigger-relative read index (ADDR_W)
//    rd_data       out  read data, 1 cycle after rd_en
//    rd_oor        out  rd_idx was >= DEPTH
//    capture_done  out  a record is frozen and readable
//    trig_forced   out  the record was closed by the auto timeout
//    busy          out  acquisition in progress
// ============================================================================
module wave_capture #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 300,
    parameter int ADDR_W   = 9,
    parameter int PRE_TRIG = 150,
    parameter int HYST     = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic              ad_clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              run,
    input  logic              arm,
    input  logic [1:0]        trig_mode,
    input  logic [1:0]        trig_edge,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              rd_done,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_idx,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_oor,
    output logic              capture_done,
    output logic              trig_forced,
    output logic              busy
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_pre_last  = ADDR_W'(PRE_TRIG - 1);
    localparam logic [ADDR_W-1:0] c_post_load = ADDR_W'(DEPTH - PRE_TRIG - 1);
    localparam logic [TO_W-1:0]   c_to_one    = TO_W'(1);
    localparam logic [TO_W-1:0]   c_to_last   = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0]   c_to_max    = TO_W'(TIMEOUT);
    localparam logic [ADDR_W+1:0] c_depth_x   = (ADDR_W + 2)'(DEPTH);
    localparam logic [ADDR_W+1:0] c_rd_off    = (ADDR_W + 2)'(DEPTH - PRE_TRIG);
    localparam logic [DATA_W:0]   c_hyst_x    = (DATA_W + 1)'(HYST);
    localparam logic [DATA_W:0]   c_data_max  = {1'b0, {DATA_W{1'b1}}};
    localparam logic [1:0]        c_mode_auto   = 2'd1;
    localparam logic [1:0]        c_mode_single = 2'd2;
    localparam logic [1:0]        c_edge_rise   = 2'd0;
    localparam logic [1:0]        c_edge_fall   = 2'd1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRE_FILL  = 3'd1,
        S_ARMED     = 3'd2,
        S_POST_FILL = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [ADDR_W-1:0]   r_trig_addr;
    logic [ADDR_W-1:0]   r_pre_cnt;
    logic [ADDR_W-1:0]   r_post_cnt;
    logic [TO_W-1:0]     r_to_cnt;
    logic                r_below;
    logic                r_above;
    logic                r_forced;
    logic                r_busy;
    logic                r_trig_forced;
    logic                r_capture_done;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rd_oor;

    logic                w_wr;
    logic                w_single;
    logic                w_auto;
    logic [DATA_W:0]     w_level_x;
    logic [DATA_W:0]     w_din_x;
    logic [DATA_W:0]     w_lo;
    logic [DATA_W:0]     w_hi_sum;
    logic [DATA_W:0]     w_hi;
    logic                w_set_below;
    logic                w_clr_below;
    logic                w_set_above;
    logic                w_clr_above;
    logic                w_rise;
    logic                w_fall;
    logic                w_trig;
    logic                w_force;
    logic [ADDR_W+1:0]   w_phys_sum;
    logic [ADDR_W+1:0]   w_phys_1;
    logic [ADDR_W+1:0]   w_phys_2;
    logic                w_oor;

    // ------------------------------------------------------------------
    // Trigger qualification
    // ------------------------------------------------------------------
    always_comb begin
        w_single  = (trig_mode == c_mode_single);
        w_auto    = (trig_mode == c_mode_auto);
        w_level_x = {1'b0, trig_level};
        w_din_x   = {1'b0, din};

        // Thresholds one bit wider than the data so they saturate cleanly.
        w_lo     = (w_level_x > c_hyst_x) ? (w_level_x - c_hyst_x) : '0;
        w_hi_sum = w_level_x + c_hyst_x;
        w_hi     = (w_hi_sum > c_data_max) ? c_data_max : w_hi_sum;

        w_set_below = (w_din_x < w_lo);
        w_clr_below = (din >= trig_level);
        w_set_above = (w_din_x > w_hi);
        w_clr_above = (din <= trig_level);

        // Edge detection uses the flags as they were before this sample.
        w_rise = r_below && w_clr_below;
        w_fall = r_above && w_clr_above;

        case (trig_edge)
            c_edge_rise: w_trig = w_rise;
            c_edge_fall: w_trig = w_fall;
            default:     w_trig = w_rise || w_fall;
        endcase

        w_force = w_auto && (r_to_cnt >= c_to_last);

        // A write happens only while acquiring; the abort cycle and an empty
        // post-trigger count do not write.
        w_wr = din_valid && run &&
               ((r_state == S_PRE_FILL) || (r_state == S_ARMED) ||
                ((r_state == S_POST_FILL) && (r_post_cnt != '0)));
    end

    // ------------------------------------------------------------------
    // Control state machine
    // ------------------------------------------------------------------
    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_wr_addr      <= '0;
            r_trig_addr    <= '0;
            r_pre_cnt      <= '0;
            r_post_cnt     <= '0;
            r_to_cnt       <= '0;
            r_below        <= 1'b0;
            r_above        <= 1'b0;
            r_forced       <= 1'b0;
            r_busy         <= 1'b0;
            r_trig_forced  <= 1'b0;
            r_capture_done <= 1'b0;
        end else begin
            if (din_valid) begin
                if (w_set_below) begin
                    r_below <= 1'b1;
                end else if (w_clr_below) begin
                    r_below <= 1'b0;
                end
                if (w_set_above) begin
                    r_above <= 1'b1;
                end else if (w_clr_above) begin
                    r_above <= 1'b0;
                end
            end

            if (w_wr) begin
                r_wr_addr <= (r_wr_addr == c_last_addr) ? '0 : (r_wr_addr + c_addr_one);
            end

            // Status outputs are decodes of the current state register, so
            // they follow a state change by one cycle.
            r_busy        <= (r_state == S_PRE_FILL) || (r_state == S_ARMED) ||
                             (r_state == S_POST_FILL);
            r_trig_forced <= r_forced;

            case (r_state)
                S_IDLE: begin
                    if (run && (!w_single || arm)) begin
                        r_state   <= S_PRE_FILL;
                        r_pre_cnt <= '0;
                        r_forced  <= 1'b0;
                    end
                end

                S_PRE_FILL: begin
                    if (!run) begin
                        r_state <= S_IDLE;
                    end else if (din_valid) begin
                        if (r_pre_cnt == c_pre_last) begin
                            r_state  <= S_ARMED;
                            r_to_cnt <= '0;
                        end else begin
                            r_pre_cnt <= r_pre_cnt + c_addr_one;
                        end
                    end
                end

                S_ARMED: begin
                    if (!run) begin
                        r_state <= S_IDLE;
                    end else if (din_valid) begin
                        if (w_trig || w_force) begin
                            r_state     <= S_POST_FILL;
                            r_trig_addr <= r_wr_addr;
                            r_post_cnt  <= c_post_load;
                            // A real edge on the timeout sample wins.
                            r_forced    <= !w_trig;
                        end else if (r_to_cnt != c_to_max) begin
                            r_to_cnt <= r_to_cnt + c_to_one;
                        end
                    end
                end

                S_POST_FILL: begin
                    if (!run) begin
                        r_state <= S_IDLE;
                    end else if (r_post_cnt == '0) begin
                        r_state        <= S_DONE;
                        r_capture_done <= 1'b1;
                    end else if (din_valid) begin
                        r_post_cnt <= r_post_cnt - c_addr_one;
                        if (r_post_cnt == c_addr_one) begin
                            r_state        <= S_DONE;
                            r_capture_done <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    if (rd_done) begin
                        r_capture_done <= 1'b0;
                        if (!w_single && run) begin
                            r_state   <= S_PRE_FILL;
                            r_pre_cnt <= '0;
                            r_forced  <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end

                default: begin
                    r_state        <= S_IDLE;
                    r_capture_done <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sample storage
    // ------------------------------------------------------------------
    always_ff @(posedge ad_clk) begin
        if (w_wr) begin
            r_mem[r_wr_addr] <= din;
        end
    end

    // ------------------------------------------------------------------
    // Trigger-relative read path
    // ------------------------------------------------------------------
    always_comb begin
        // Oldest sample sits PRE_TRIG slots before the trigger; adding
        // DEPTH - PRE_TRIG keeps the sum non-negative. For in-range indices
        // the sum is below 3*DEPTH, so two subtractions fold it back.
        w_phys_sum = {2'b00, r_trig_addr} + c_rd_off + {2'b00, rd_idx};
        w_phys_1   = (w_phys_sum >= c_depth_x) ? (w_phys_sum - c_depth_x) : w_phys_sum;
        w_phys_2   = (w_phys_1 >= c_depth_x) ? (w_phys_1 - c_depth_x) : w_phys_1;
        w_oor      = ({2'b00, rd_idx} >= c_depth_x);
    end

    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
            r_rd_oor  <= 1'b0;
        end else if (rd_en) begin
            r_rd_oor  <= w_oor;
            r_rd_data <= w_oor ? '0 : r_mem[w_phys_2[ADDR_W-1:0]];
        end
    end

    assign rd_data      = r_rd_data;
    assign rd_oor       = r_rd_oor;
    assign capture_done = r_capture_done;
    assign trig_forced  = r_trig_forced;
    assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_wave_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wave_capture
//  Description : Directed self-checking bench for wave_capture. Read requests
//                push their expected result to a scoreboard queue; the value
//                is popped and compared when the registered read data appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wave_capture;

    localparam int DW    = 8;
    localparam int DEPTH = 300;
    localparam int AW    = 9;
    localparam int PRE   = 150;
    localparam int HY    = 4;
    localparam int TO    = 16;

    logic          ad_clk = 1'b0;
    logic          rst_n  = 1'b1;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          run;
    logic          arm;
    logic [1:0]    trig_mode;
    logic [1:0]    trig_edge;
    logic [DW-1:0] trig_level;
    logic          rd_done;
    logic          rd_en;
    logic [AW-1:0] rd_idx;
    logic [DW-1:0] rd_data;
    logic          rd_oor;
    logic          capture_done;
    logic          trig_forced;
    logic          busy;

    always #5 ad_clk = ~ad_clk;

    wave_capture #(
        .DATA_W   (DW),
        .DEPTH    (DEPTH),
        .ADDR_W   (AW),
        .PRE_TRIG (PRE),
        .HYST     (HY),
        .TIMEOUT  (TO)
    ) dut (
        .ad_clk       (ad_clk),
        .rst_n        (rst_n),
        .din          (din),
        .din_valid    (din_valid),
        .run          (run),
        .arm          (arm),
        .trig_mode    (trig_mode),
        .trig_edge    (trig_edge),
        .trig_level   (trig_level),
        .rd_done      (rd_done),
        .rd_en        (rd_en),
        .rd_idx       (rd_idx),
        .rd_data      (rd_data),
        .rd_oor       (rd_oor),
        .capture_done (capture_done),
        .trig_forced  (trig_forced),
        .busy         (busy)
    );

    typedef struct {
        string         tag;
        logic [DW-1:0] data;
        logic          oor;
    } rd_exp_t;

    rd_exp_t sb[$];
    int      n_tests = 0;
    int      n_fail  = 0;
    int      wr_ptr  = 0;   // model of the DUT write pointer

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge ad_clk);
            din_valid = 1'b0;
            rd_en     = 1'b0;
        end
    endtask

    // One written sample per cycle; outputs are valid on return.
    task automatic send(input logic [DW-1:0] v);
        @(negedge ad_clk);
        din       = v;
        din_valid = 1'b1;
        rd_en     = 1'b0;
        @(posedge ad_clk);
        #1;
        wr_ptr = (wr_ptr + 1) % DEPTH;
    endtask

    task automatic rd(input string tag, input int idx, input logic [DW-1:0] d, input logic oor);
        rd_exp_t e;
        @(negedge ad_clk);
        din_valid = 1'b0;
        rd_en     = 1'b1;
        rd_idx    = idx[AW-1:0];
        e.tag  = tag;
        e.data = d;
        e.oor  = oor;
        sb.push_back(e);
        @(posedge ad_clk);
        #1;
        e = sb.pop_front();
        check({e.tag, "_data"}, 32'(rd_data), 32'(e.data));
        check({e.tag, "_oor"},  32'(rd_oor),  32'(e.oor));
    endtask

    task automatic release_rec(input logic keep_run);
        @(negedge ad_clk);
        din_valid = 1'b0;
        rd_en     = 1'b0;
        run       = keep_run;
        rd_done   = 1'b1;
        @(negedge ad_clk);
        rd_done   = 1'b0;
        idle(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        din = '0; din_valid = 1'b0; run = 1'b0; arm = 1'b0;
        trig_mode = 2'd0; trig_edge = 2'd0; trig_level = 8'd128;
        rd_done = 1'b0; rd_en = 1'b0; rd_idx = '0;

        // ---------------- reset state ----------------
        #2 rst_n = 1'b0;
        #1;
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_rd_oor", 32'(rd_oor), 0);
        check("rst_done", 32'(capture_done), 0);
        check("rst_forced", 32'(trig_forced), 0);
        check("rst_busy", 32'(busy), 0);
        repeat (3) @(posedge ad_clk);
        @(negedge ad_clk) rst_n = 1'b1;

        // ---------------- normal mode, rising, ramp ----------------
        @(negedge ad_clk) run = 1'b1;
        idle(2);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            send(DW'(i % 256));
            n++;
            if (capture_done) break;
        end
        check("ramp_samples", n, 534);
        check("ramp_done", 32'(capture_done), 1);
        check("ramp_forced", 32'(trig_forced), 0);
        rd("ramp_idx150", 150, 8'd128, 1'b0);
        rd("ramp_idx149", 149, 8'd127, 1'b0);
        rd("ramp_idx151", 151, 8'd129, 1'b0);
        rd("ramp_idx0",   0,   8'd234, 1'b0);
        rd("ramp_idx299", 299, 8'd21,  1'b0);
        idle(2);
        check("ramp_hold", 32'(rd_data), 21);
        check("ramp_done_busy", 32'(busy), 0);
        release_rec(1'b0);
        check("ramp_released", 32'(capture_done), 0);

        // ---------------- hysteresis ----------------
        @(negedge ad_clk) run = 1'b1;
        idle(2);
        for (int i = 0; i < 350; i++) send(DW'(126 + (i % 5)));
        check("hyst_busy", 32'(busy), 1);
        check("hyst_no_trig", 32'(capture_done), 0);
        send(8'd120);
        send(8'd130);
        check("hyst_not_done", 32'(capture_done), 0);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            send(8'd128);
            n++;
            if (capture_done) break;
        end
        check("hyst_post_samples", n, 149);
        rd("hyst_idx150", 150, 8'd130, 1'b0);
        rd("hyst_idx149", 149, 8'd120, 1'b0);
        rd("hyst_idx151", 151, 8'd128, 1'b0);
        release_rec(1'b0);

        // ---------------- auto mode, flat input ----------------
        trig_mode = 2'd1;
        @(negedge ad_clk) run = 1'b1;
        idle(2);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            send(8'd50);
            n++;
            if (capture_done) break;
        end
        check("auto_samples", n, PRE + TO + (DEPTH - PRE - 1));
        idle(1);
        check("auto_forced", 32'(trig_forced), 1);
        rd("auto_idx150", 150, 8'd50, 1'b0);
        release_rec(1'b0);
        trig_mode = 2'd0;

        // ---------------- single mode ----------------
        trig_mode = 2'd2;
        @(negedge ad_clk) run = 1'b1;
        idle(5);
        check("single_wait_arm", 32'(busy), 0);
        @(negedge ad_clk) arm = 1'b1;
        @(negedge ad_clk) arm = 1'b0;
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            send(DW'(i % 256));
            n++;
            if (capture_done) break;
        end
        check("single_samples", n, 534);
        check("single_forced", 32'(trig_forced), 0);
        release_rec(1'b1);
        idle(8);
        check("single_idle_busy", 32'(busy), 0);
        check("single_idle_done", 32'(capture_done), 0);
        @(negedge ad_clk) arm = 1'b1;
        @(negedge ad_clk) arm = 1'b0;
        idle(3);
        check("single_rearm_busy", 32'(busy), 1);
        @(negedge ad_clk) run = 1'b0;
        idle(3);
        check("single_stop_busy", 32'(busy), 0);
        trig_mode = 2'd0;

        // ---------------- abort mid post-fill ----------------
        @(negedge ad_clk) run = 1'b1;
        idle(2);
        for (int i = 0; i < 435; i++) send(DW'(i % 256));
        check("abort_busy_before", 32'(busy), 1);
        check("abort_done_before", 32'(capture_done), 0);
        @(negedge ad_clk);
        din_valid = 1'b0;
        run       = 1'b0;
        idle(3);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(capture_done), 0);

        // ---------------- wrap: trigger at DEPTH-2 ----------------
        trig_edge = 2'd2;
        @(negedge ad_clk) run = 1'b1;
        idle(2);
        for (int i = 0; i < PRE; i++) send(8'd100);
        k = (DEPTH - 2 - wr_ptr + DEPTH) % DEPTH;
        for (int i = 0; i < k; i++) send(8'd100);
        send(8'd200);
        n = 0;
        for (int j = 0; j < 400; j++) begin
            send(DW'(10 + j));
            n++;
            if (capture_done) break;
        end
        check("wrap_post_samples", n, 149);
        rd("wrap_idx150", 150, 8'd200, 1'b0);
        rd("wrap_idx151", 151, 8'd10,  1'b0);
        rd("wrap_idx152", 152, 8'd11,  1'b0);
        rd("wrap_idx149", 149, 8'd100, 1'b0);
        rd("wrap_idx0",   0,   8'd100, 1'b0);
        rd("wrap_idx299", 299, 8'd158, 1'b0);
        rd("wrap_idx300", 300, 8'd0,   1'b1);
        rd("wrap_idx511", 511, 8'd0,   1'b1);
        release_rec(1'b0);
        trig_edge = 2'd0;

        // ---------------- reset while armed ----------------
        @(negedge ad_clk) run = 1'b1;
        idle(2);
        for (int i = 0; i < 160; i++) send(8'd100);
        rd("armed_idx300", 300, 8'd0, 1'b1);
        idle(1);
        check("armed_busy", 32'(busy), 1);
        @(negedge ad_clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_rd_oor", 32'(rd_oor), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(capture_done), 0);
        check("arst_forced", 32'(trig_forced), 0);
        check("arst_rd_data", 32'(rd_data), 0);
        run = 1'b0;
        @(negedge ad_clk) rst_n = 1'b1;
        wr_ptr = 0;
        idle(3);
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_done", 32'(capture_done), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wave_capture.md
# wave_capture

Parametrised trigger-and-capture buffer for the oscilloscope datapath. It sits after the decimator and holds a configurable-depth record of decimated ADC samples around a trigger point. It adds normal, auto and single trigger modes, hysteresis, rising/falling/either edge selection and a done/release handshake. The display or CPU reads the frozen record by trigger-relative index.

## Interface
- `DATA_W`, 8: sample width.
- `DEPTH`, 300: samples per record, ≥ 4.
- `ADDR_W`, 9: buffer address width; 2^ADDR_W ≥ DEPTH.
- `PRE_TRIG`, 150: samples stored before the trigger sample; 1 ≤ PRE_TRIG ≤ DEPTH-2.
- `HYST`, 4: hysteresis in LSBs.
- `TIMEOUT`, 1024: auto-mode timeout, counted in valid samples; ≥ 1.
- `ad_clk` in 1: the single clock for the whole block. Reset is asynchronous and active-low.
- `rst_n` in 1: asynchronous active-low reset.
- `din` in DATA_W: decimated sample.
- `din_valid` in 1: sample strobe.
- `run` in 1: acquisition enable (level).
- `arm` in 1: single-mode arm pulse.
- `trig_mode` in 2: 0 = normal, 1 = auto, 2 = single, 3 = treated as normal.
- `trig_edge` in 2: 0 = rising, 1 = falling, 2/3 = either.
- `trig_level` in DATA_W: trigger threshold.
- `rd_done` in 1: reader has finished with the record; releases DONE.
- `rd_en` in 1: read strobe.
- `rd_idx` in ADDR_W: trigger-relative index; 0 is the oldest sample, PRE_TRIG is the trigger sample.
- `rd_data` out DATA_W: read data.
- `rd_oor` out 1: rd_idx ≥ DEPTH.
- `capture_done` out 1: a record is frozen and readable.
- `trig_forced` out 1: the record was closed by the auto timeout.
- `busy` out 1: state is PRE_FILL, ARMED or POST_FILL.

## Operation
- States are IDLE, PRE_FILL, ARMED, POST_FILL and DONE. Reset enters IDLE.
- **IDLE**
  - Go to PRE_FILL when `run`=1 and the mode is not single.
  - In single mode, go to PRE_FILL when `run`=1 and `arm`=1.
  - On entry to PRE_FILL, clear the sample counter and `trig_forced`.
- **Writing.** In PRE_FILL, ARMED and POST_FILL, every `din_valid` writes `din` to `wr_addr`. `wr_addr` then increments and wraps from DEPTH-1 to 0. `wr_addr` is not reset between records.
- **PRE_FILL.** Count valid samples. After PRE_TRIG samples have been written, go to ARMED.
- **Hysteresis flags**, updated on each valid sample in every state:
  - `below` is set when din < trig_level − HYST (saturating at 0) and cleared when din ≥ trig_level.
  - `above` is set when din > trig_level + HYST (saturating at 2^DATA_W − 1) and cleared when din ≤ trig_level.
- **Trigger event**, evaluated against the flag values before the update:
  - Rising: `below`=1 and din ≥ trig_level.
  - Falling: `above`=1 and din ≤ trig_level.
  - Either: rising or falling.
- **ARMED**
  - On a valid sample that is a trigger event, latch `trig_addr` = that sample's `wr_addr`. Load `post_cnt` = DEPTH − PRE_TRIG − 1 and go to POST_FILL.
  - Auto mode: a timeout counter increments per valid sample while ARMED. When it reaches TIMEOUT, that sample is a forced trigger and `trig_forced` is set.
  - A real trigger on the same sample takes precedence, and `trig_forced` stays 0.
- **POST_FILL.** Decrement `post_cnt` on each valid sample. The write that takes it to 0 is the last one, and the block goes to DONE. If `post_cnt` is 0 on entry, go straight to DONE with no further write.
- **DONE**
  - Writes stop and `capture_done`=1.
  - On `rd_done`: single mode goes to IDLE; otherwise go to PRE_FILL if `run`=1, or IDLE if `run`=0.
- **Abort.** `run`=0 in PRE_FILL, ARMED or POST_FILL returns to IDLE and discards the partial record. `run`=0 in DONE does not discard the record.
- **Read path** (usable in any state, meaningful in DONE):
  - phys = (trig_addr + DEPTH − PRE_TRIG + rd_idx) mod DEPTH. Compute it with ADDR_W+2-bit arithmetic and at most two conditional subtractions of DEPTH.
  - When rd_idx ≥ DEPTH, `rd_oor`=1 and `rd_data`=0.

## Timing
- Reset values: all outputs 0. Also state IDLE, `wr_addr`=0, `trig_addr`=0, `below`/`above`=0, and all counters 0.
- Read latency is 1 cycle. `rd_data` and `rd_oor` are registered on the cycle after `rd_en`=1 and hold while `rd_en`=0.
- `capture_done` rises on the cycle after the final post-trigger write. It falls on the cycle after `rd_done` is sampled.
- `busy` and `trig_forced` are registered state decodes and update 1 cycle after the state change.
- If `rd_done` is asserted outside DONE, it is ignored.
- `arm` outside IDLE is ignored. `trig_mode` and `trig_edge` are sampled live every cycle.

## Test plan
- **Normal, rising edge.** Parameters 300/150, HYST=4, level=128, ramp 0→255 repeating. Required: trigger on the first sample ≥128 after PRE_FILL, `rd_idx`=150 returns that sample, and `rd_idx` 149/151 return its neighbours.
- **Hysteresis.** Noise 126..130 around level 128. Required: no trigger and the block stays ARMED. Then one dip to 120 followed by 130 produces a trigger.
- **Auto mode, flat din.** TIMEOUT=16, flat din=50. Required: DONE after 150 + 16 + 149 valid samples with `trig_forced`=1.
- **Single mode.** Pulse `arm` once and capture one record, then pulse `rd_done`. Required: the block returns to IDLE and stays there despite `run`=1 until the next `arm` pulse.
- **Abort and wrap.** Drop `run` mid-POST_FILL. Required: IDLE and `capture_done`=0. Then re-run so that `trig_addr` lands near DEPTH−1, and check that wrapped reads and `rd_idx`=300 give `rd_oor`=1 and `rd_data`=0.
- **Reset mid-capture.** Assert `rst_n`=0 in ARMED. Required: all outputs 0 immediately (asynchronous reset) and IDLE after release.
